// File: rtl/regfile_write_scheduler.sv
// Write-port owner for the 32x32 integer register file: pipeline writeback first,
// then buffered or bypassed long-latency results, plus the decode busy scoreboard.
module regfile_write_scheduler #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_we,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data,
  input  logic [31:0]      wb_pc,
  input  logic             md_issue,
  input  logic [4:0]       md_dst,
  output logic             issue_stall,
  input  logic             md_valid,
  output logic             md_ready,
  input  logic [4:0]       md_addr,
  input  logic [31:0]      md_data,
  input  logic [31:0]      md_pc,
  input  logic [4:0]       dec_a1,
  input  logic [4:0]       dec_a2,
  input  logic [4:0]       dec_a3,
  output logic             dec_stall,
  output logic             rf_we,
  output logic [4:0]       rf_addr,
  output logic [31:0]      rf_data,
  output logic [31:0]      rf_pc,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] buf_count
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DATA_W = 32;

  // DEPTH is a power of two, so plain binary increment wraps the pointer.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] nextCount(input logic [CNT_W-1:0] c,
                                                 input logic inc,
                                                 input logic dec);
    logic [CNT_W-1:0] r;
    r = c;
    if (inc && !dec)
      r = c + CNT_W'(1);
    else if (dec && !inc)
      r = c - CNT_W'(1);
    return r;
  endfunction

  logic [4:0]        fifoAddr [DEPTH];
  logic [DATA_W-1:0] fifoData [DEPTH];
  logic [DATA_W-1:0] fifoPc   [DEPTH];

  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  bufCount;
  logic [31:0]       busyReg;
  logic [31:0]       busyNext;

  logic              fifoEmpty;
  logic              mdReady;
  logic              pop;
  logic              bypass;
  logic              push;
  logic              mdWrite;
  logic              setBusy;
  logic              issueStall;

  assign fifoEmpty = (bufCount == '0);
  // Ready depends on occupancy only, never on md_valid.
  assign mdReady   = !rst && (bufCount < CNT_W'(DEPTH));

  always_comb begin
    rf_we   = 1'b0;
    rf_addr = '0;
    rf_data = '0;
    rf_pc   = '0;
    pop     = 1'b0;
    bypass  = 1'b0;
    if (!rst) begin
      if (wb_we) begin
        rf_we   = 1'b1;
        rf_addr = wb_addr;
        rf_data = wb_data;
        rf_pc   = wb_pc;
      end else if (!fifoEmpty) begin
        rf_we   = 1'b1;
        rf_addr = fifoAddr[rdPtr];
        rf_data = fifoData[rdPtr];
        rf_pc   = fifoPc[rdPtr];
        pop     = 1'b1;
      end else if (md_valid && mdReady) begin
        rf_we   = 1'b1;
        rf_addr = md_addr;
        rf_data = md_data;
        rf_pc   = md_pc;
        bypass  = 1'b1;
      end
    end
  end

  assign push       = md_valid && mdReady && !bypass;
  assign mdWrite    = pop || bypass;
  assign issueStall = !rst && md_issue && (md_dst != 5'd0) && busyReg[md_dst];
  assign setBusy    = !rst && md_issue && !issueStall && (md_dst != 5'd0);

  // Clear first, then set, so a same-register set in the same cycle wins.
  always_comb begin
    busyNext = busyReg;
    if (mdWrite)
      busyNext[rf_addr] = 1'b0;
    if (setBusy)
      busyNext[md_dst] = 1'b1;
    busyNext[0] = 1'b0;
  end

  // Result buffer storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoAddr[wrPtr] <= md_addr;
      fifoData[wrPtr] <= md_data;
      fifoPc[wrPtr]   <= md_pc;
    end
  end

  // Control state: pointers, occupancy and scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      bufCount <= '0;
      busyReg  <= '0;
    end else begin
      if (push)
        wrPtr <= nextPtr(wrPtr);
      if (pop)
        rdPtr <= nextPtr(rdPtr);
      bufCount <= nextCount(bufCount, push, pop);
      busyReg  <= busyNext;
    end
  end

  assign md_ready    = mdReady;
  assign issue_stall = issueStall;
  assign dec_stall   = !rst && (busyReg[dec_a1] || busyReg[dec_a2] || busyReg[dec_a3]);
  assign busy_mask   = {busyReg[31:1], 1'b0};
  assign buf_count   = bufCount;

endmodule
